// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// FSM state encoding and requester IDs.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Generic 2-to-1 mux: s = 0 selects a, s = 1 selects b.
module mem_port_arbiter_mux #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch and a data
// requester, with round-robin tie-break, per-transaction timeout and done pulses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              req_d,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] wdata_d,
    input  logic              we_d,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              sel,
    output logic              ack_i,
    output logic              ack_d,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state, state_nxt;
    req_id_t           last_served, winner;
    logic              grant, done, expire;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_win;

    mem_port_arbiter_mux #(.W(ADDR_W)) u_addr_mux (
        .a (addr_i),
        .b (addr_d),
        .s (winner),
        .y (addr_win)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_nxt = state;
        grant     = 1'b0;
        winner    = REQ_I;
        done      = 1'b0;
        expire    = 1'b0;
        unique case (state)
            IDLE: begin
                grant = req_i | req_d;
                if (req_i && req_d) winner = other_req(last_served);
                else if (req_d)     winner = REQ_D;
                if (grant) state_nxt = (winner == REQ_D) ? BUSY_D : BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                // A completion on the final wait cycle beats the timeout.
                if (mem_ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            sel         <= 1'b0;
            ack_i       <= 1'b0;
            ack_d       <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            wait_cnt    <= '0;
            last_served <= REQ_I;
        end else begin
            ack_i <= done && (state == BUSY_I);
            ack_d <= done && (state == BUSY_D);
            err   <= expire;

            // Port-side outputs load only on grant and hold for the transaction.
            if (grant) begin
                mem_addr  <= addr_win;
                mem_wdata <= (winner == REQ_D) ? wdata_d : '0;
                mem_we    <= (winner == REQ_D) && we_d;
                sel       <= winner;
                wait_cnt  <= '0;
            end else if (mem_req && !done && !expire) begin
                wait_cnt  <= wait_cnt + 1'b1;
            end

            if (done) begin
                rdata       <= mem_rdata;
                last_served <= (state == BUSY_D) ? REQ_D : REQ_I;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a driver pushes expected transaction
// outcomes from a transaction-level model; a monitor pops and compares them.
module tb_mem_port_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              reset;
    logic              req_i, req_d, we_d, mem_ack;
    logic [ADDR_W-1:0] addr_i, addr_d;
    logic [DATA_W-1:0] wdata_d, mem_rdata;
    logic              mem_req, mem_we, sel, ack_i, ack_d, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, rdata;

    mem_port_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .req_d     (req_d),
        .addr_d    (addr_d),
        .wdata_d   (wdata_d),
        .we_d      (we_d),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .sel       (sel),
        .ack_i     (ack_i),
        .ack_d     (ack_d),
        .rdata     (rdata),
        .err       (err)
    );

    // kind: 0 = ack_i, 1 = ack_d, 2 = err; lat counted in cycles from grant.
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        sel;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          n_checks;
    int          n_pass;
    bit          m_last;
    logic [31:0] m_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_sel",       64'(sel),       64'd0);
        check("rst_ack_i",     64'(ack_i),     64'd0);
        check("rst_ack_d",     64'(ack_d),     64'd0);
        check("rst_err",       64'(err),       64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata",     64'(rdata),     64'd0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        bit   busy;
        bit   hold_ok;
        int   lat;
        int   kind_act;
        exp_t cur;
        busy = 0;
        hold_ok = 1;
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                busy = 0;
                check("no_pulse_in_reset", 64'({ack_i, ack_d, err}), 64'd0);
                continue;
            end
            if (!busy && mem_req) begin
                if (q.size() == 0) begin
                    check("spurious_grant", 64'(mem_req), 64'd0);
                end else begin
                    cur = q[0];
                    check("grant_addr",  64'(mem_addr),  64'(cur.addr));
                    check("grant_we",    64'(mem_we),    64'(cur.we));
                    check("grant_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    check("grant_sel",   64'(sel),       64'(cur.sel));
                    busy = 1;
                    lat = 0;
                    hold_ok = 1;
                end
            end else if (busy) begin
                lat++;
                if (mem_req && (mem_addr !== cur.addr || mem_we !== cur.we ||
                                mem_wdata !== cur.wdata || sel !== cur.sel))
                    hold_ok = 0;
            end
            if (ack_i || ack_d || err) begin
                if (!busy || q.size() == 0) begin
                    check("unexpected_pulse", 64'({ack_i, ack_d, err}), 64'd0);
                end else begin
                    cur = q.pop_front();
                    kind_act = ack_i ? 0 : (ack_d ? 1 : 2);
                    check("pulse_exclusive", 64'($countones({ack_i, ack_d, err})), 64'd1);
                    check("outcome_kind",    64'(kind_act), 64'(cur.kind));
                    check("outcome_rdata",   64'(rdata),    64'(cur.rdata));
                    check("outcome_latency", 64'(lat),      64'(cur.lat));
                    check("outputs_held",    64'(hold_ok),  64'd1);
                    check("idle_after_done", 64'(mem_req),  64'd0);
                    busy = 0;
                end
            end
        end
    end

    // One transaction, starting at a falling edge with the DUT in IDLE.
    // w >= 0: mem_ack sampled w+1 edges after grant; w < 0: no ack (timeout).
    task automatic do_txn(input bit ri, input bit rd, input logic [31:0] ai,
                          input logic [31:0] ad, input logic [31:0] wd, input bit we,
                          input int w, input logic [31:0] rv, input bit drop);
        exp_t e;
        bit   win;
        int   n;
        req_i = ri; req_d = rd; addr_i = ai; addr_d = ad; wdata_d = wd; we_d = we;
        win     = (ri && rd) ? !m_last : rd;
        e.sel   = win;
        e.addr  = win ? ad : ai;
        e.we    = win ? we : 1'b0;
        e.wdata = win ? wd : 32'd0;
        if (w >= 0) begin
            e.kind  = win ? 1 : 0;
            e.rdata = rv;
            e.lat   = w + 1;
            m_last  = win;
            m_rdata = rv;
        end else begin
            e.kind  = 2;
            e.rdata = m_rdata;
            e.lat   = TIMEOUT;
        end
        q.push_back(e);

        n = 0;
        @(negedge clk);
        while (!mem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", 64'(mem_req), 64'd1);
        if (!mem_req) begin
            q.delete();
            return;
        end

        // Scramble the requester inputs: the port must keep what it latched.
        addr_i = $urandom; addr_d = $urandom; wdata_d = $urandom; we_d = 1'($urandom);
        if (drop) begin
            req_i = 1'b0;
            req_d = 1'b0;
        end
        for (int k = 0; k < TIMEOUT; k++) begin
            if (k == w) begin
                mem_ack = 1'b1;
                mem_rdata = rv;
                @(negedge clk);
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle_gap(input int n);
        req_i = 1'b0;
        req_d = 1'b0;
        for (int k = 0; k < n; k++) begin
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        bit [1:0] rr;
        int       w;
        n_checks = 0; n_pass = 0; m_last = 0; m_rdata = 32'd0;
        reset = 1'b0; req_i = 1'b0; req_d = 1'b0; we_d = 1'b0; mem_ack = 1'b0;
        addr_i = '0; addr_d = '0; wdata_d = '0; mem_rdata = '0;
        #1 reset = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Tie with both requests held: D, I, D.
        for (int k = 0; k < 3; k++)
            do_txn(1, 1, 32'h0000_1000 + 32'(k), 32'h0000_2000 + 32'(k), 32'hA5A5_0000 + 32'(k),
                   1'b0, 1, 32'hC0DE_0000 + 32'(k), 1'b0);

        // Single read, write, timeout.
        do_txn(1, 0, 32'h100, 32'h0, 32'h0, 1'b0, 2, 32'hDEAD_BEEF, 1'b0);
        do_txn(0, 1, 32'h0, 32'h200, 32'h1234_5678, 1'b1, 3, 32'h5555_AAAA, 1'b0);
        do_txn(0, 1, 32'h0, 32'h240, 32'h0BAD_F00D, 1'b1, -1, 32'h0, 1'b0);
        idle_gap(3);

        // Reset in BUSY_I: abandoned with no pulse, then a normal fetch.
        req_i = 1'b1; addr_i = 32'h300;
        q.push_back('{kind: 0, addr: 32'h300, we: 1'b0, wdata: 32'h0, sel: 1'b0,
                      rdata: 32'h0, lat: 0});
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 check_reset_outputs();
        q.delete();
        m_last = 0;
        m_rdata = 32'd0;
        req_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle_gap(1);
        do_txn(1, 0, 32'h304, 32'h0, 32'h0, 1'b0, 1, 32'h1111_2222, 1'b0);

        // Late ack on the final wait cycle, plus abandoned request levels.
        do_txn(1, 0, 32'h400, 32'h0, 32'h0, 1'b0, TIMEOUT - 1, 32'h7777_8888, 1'b0);
        do_txn(1, 1, 32'h500, 32'h600, 32'h9999_0000, 1'b1, 0, 32'h4242_4242, 1'b1);

        for (int t = 0; t < 80; t++) begin
            rr = 2'($urandom_range(1, 3));
            w = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
            do_txn(rr[0], rr[1], $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   w, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
        end

        idle_gap(4);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
